// File: rtl/frame_buffer_arbiter.sv
// Frame buffer arbiter: queues SPI pixel writes, gives display reads priority,
// drives one sync-read RAM port. Optional macro: FB_ARB_STARVE_GUARD_EN.
//
// Ports:
//   mainClk, nreset          clock, async active-low reset
//   wrValid/wrX/wrY/wrData   pixel write request; wrOverflow flags a drop
//   rdReq/rdX/rdY            pixel read request; rdData/rdValid at N+2
//   ramAddr/ramWe/ramWdata   registered RAM command; ramRdata sync read data
//   fifoLevel                write queue occupancy
module frame_buffer_arbiter #(
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int DATA_W     = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              mainClk,
  input  logic              nreset,
  input  logic              wrValid,
  input  logic [9:0]        wrX,
  input  logic [8:0]        wrY,
  input  logic [DATA_W-1:0] wrData,
  output logic              wrOverflow,
  input  logic              rdReq,
  input  logic [9:0]        rdX,
  input  logic [8:0]        rdY,
  output logic [DATA_W-1:0] rdData,
  output logic              rdValid,
  output logic [18:0]       ramAddr,
  output logic              ramWe,
  output logic [DATA_W-1:0] ramWdata,
  input  logic [DATA_W-1:0] ramRdata,
  output logic [2:0]        fifoLevel
);

  localparam int AW = (FIFO_DEPTH > 1) ?
                      $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [9:0] HA = 10'(H_ACTIVE);
  localparam logic [8:0] VA = 9'(V_ACTIVE);

  typedef enum logic [1:0] {
    G_NONE,
    G_READ,
    G_WRITE
  } grant_t;

  grant_t state, state_d;

  function automatic logic [18:0] pix_addr(
    input logic [9:0] x,
    input logic [8:0] y
  );
    logic [18:0] x19;
    logic [18:0] y19;
    x19 = 19'(x);
    y19 = 19'(y);
    if (H_ACTIVE == 640)
      return (y19 << 9) + (y19 << 7) + x19;
    else
      return y19 * 19'(H_ACTIVE) + x19;
  endfunction

  logic [18:0]       q_addr [FIFO_DEPTH];
  logic [DATA_W-1:0] q_data [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count;

  logic full, empty, push, pop, wr_in_range;
  logic req_v, rd_in_range, force_wr, rd_oor;
  logic [9:0] req_x;
  logic [8:0] req_y;

  logic [18:0]       addr_d;
  logic              we_d;
  logic [DATA_W-1:0] wdata_d;

  assign full  = (count == CW'(FIFO_DEPTH));
  assign empty = (count == '0);
  assign wr_in_range = (wrX < HA) && (wrY < VA);
  assign pop  = (state_d == G_WRITE);
  // A pop in the same cycle frees the slot a full-queue push needs.
  assign push = wrValid && wr_in_range && (!full || pop);
  assign wrOverflow = wrValid && wr_in_range &&
                      full && !pop;
  assign fifoLevel = 3'(count);
  assign rd_in_range = (req_x < HA) && (req_y < VA);

`ifdef FB_ARB_STARVE_GUARD_EN
  logic [3:0] starve_cnt;
  logic       hold_v;
  logic [9:0] hold_x;
  logic [8:0] hold_y;

  // Forcing is skipped while a read is already held:
  // a second displaced read would have nowhere to go.
  assign force_wr = (starve_cnt == 4'd8) &&
                    !empty && !hold_v;
  assign req_v = hold_v | rdReq;
  assign req_x = hold_v ? hold_x : rdX;
  assign req_y = hold_v ? hold_y : rdY;

  always_ff @(posedge mainClk or negedge nreset) begin
    if (!nreset) begin
      starve_cnt <= '0;
      hold_v     <= 1'b0;
      hold_x     <= '0;
      hold_y     <= '0;
    end else begin
      if (state_d == G_READ && !empty)
        starve_cnt <= (starve_cnt == 4'd8) ?
                      4'd8 : starve_cnt + 4'd1;
      else
        starve_cnt <= '0;
      // Displaced or queued-behind reads slip one cycle.
      if (force_wr || hold_v) begin
        hold_v <= rdReq;
        hold_x <= rdX;
        hold_y <= rdY;
      end
    end
  end
`else
  assign force_wr = 1'b0;
  assign req_v = rdReq;
  assign req_x = rdX;
  assign req_y = rdY;
`endif

  always_ff @(posedge mainClk or negedge nreset) begin
    if (!nreset)
      state <= G_NONE;
    else
      state <= state_d;
  end

  always_comb begin
    state_d = G_NONE;
    if (force_wr)
      state_d = G_WRITE;
    else if (req_v)
      state_d = G_READ;
    else if (!empty)
      state_d = G_WRITE;
  end

  always_comb begin
    addr_d  = ramAddr;
    we_d    = 1'b0;
    wdata_d = ramWdata;
    unique case (state_d)
      G_READ: begin
        if (rd_in_range)
          addr_d = pix_addr(req_x, req_y);
      end
      G_WRITE: begin
        addr_d  = q_addr[rd_ptr];
        we_d    = 1'b1;
        wdata_d = q_data[rd_ptr];
      end
      default: ;
    endcase
  end

  always_ff @(posedge mainClk or negedge nreset) begin
    if (!nreset) begin
      ramAddr  <= '0;
      ramWe    <= 1'b0;
      ramWdata <= '0;
      rd_oor   <= 1'b0;
      rdValid  <= 1'b0;
      rdData   <= '0;
    end else begin
      ramAddr  <= addr_d;
      ramWe    <= we_d;
      ramWdata <= wdata_d;
      rd_oor   <= !rd_in_range;
      rdValid  <= (state == G_READ);
      rdData   <= (state == G_READ && !rd_oor) ?
                  ramRdata : '0;
    end
  end

  always_ff @(posedge mainClk) begin
    if (push) begin
      q_addr[wr_ptr] <= pix_addr(wrX, wrY);
      q_data[wr_ptr] <= wrData;
    end
  end

  always_ff @(posedge mainClk or negedge nreset) begin
    if (!nreset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule
